// File: rtl/vec_decode_stage.sv
// vec_decode_stage: ID stage of the vector encryption CPU.
// Decodes a 16-bit instruction, reads LANES replicated register files,
// tracks RAW/WAW hazards with a pending-bit scoreboard, resolves BRZ branches
// with a small FSM and drives a valid/ready ID/EX pipeline register.
// Build option: define WB_BYPASS_EN to forward same-cycle write-back data
// into the operands and to treat a register being written back as not pending.
module vec_decode_stage #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned PCW   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid_i,
    input  logic [15:0]           inst_i,
    output logic                  dec_ready_o,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_rd_i,
    input  logic [LANES-1:0]      wb_lane_mask_i,
    input  logic [LANES*DW-1:0]   wb_data_i,
    input  logic                  zero_flag_i,
    input  logic                  br_resolved_i,
    input  logic                  ex_ready_i,
    output logic                  ex_valid_o,
    output logic [LANES*DW-1:0]   ex_rs1_o,
    output logic [LANES*DW-1:0]   ex_rs2_o,
    output logic [3:0]            ex_rd_o,
    output logic [6:0]            ex_ctrl_o,
    output logic                  sel_pc_o,
    output logic [PCW-1:0]        branch_pc_o,
    output logic                  flush_o
);

    localparam int unsigned NREG  = 16;
    localparam int unsigned RAW_W = 4;
    localparam int unsigned CW    = 7;
    localparam int unsigned VW    = LANES * DW;

    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_BRZ   = 4'hA;

    // ctrl = {regWrite, memWrite, branch, resultSrc, aluCtrl[2:0]}
    localparam logic [CW-1:0] CTRL_LOAD  = 7'b100_1000;
    localparam logic [CW-1:0] CTRL_STORE = 7'b010_0000;
    localparam logic [CW-1:0] CTRL_BRZ   = 7'b001_0000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        BR_WAIT     = 2'd1,
        BR_REDIRECT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [3:0]       opcode;
    logic [RAW_W-1:0] rd, rs1, rs2;
    logic [CW-1:0]    ctrl;
    logic             uses_rs1, uses_rs2, reg_write, is_branch;

    logic [NREG-1:0]  pending, pending_next, pending_eff, wb_onehot;
    logic             hazard, issue;

    logic [VW-1:0]    rs1_val, rs2_val;
    logic [DW-1:0]    rf [LANES][NREG];

    // Instruction field split and opcode decode
    always_comb begin
        opcode   = inst_i[15:12];
        rd       = inst_i[11:8];
        rs1      = inst_i[7:4];
        rs2      = inst_i[3:0];
        ctrl     = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        if (opcode[3] == 1'b0) begin
            ctrl     = {4'b1000, opcode[2:0]};
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
        end else begin
            case (opcode)
                OP_LOAD: begin
                    ctrl     = CTRL_LOAD;
                    uses_rs1 = 1'b1;
                end
                OP_STORE: begin
                    ctrl     = CTRL_STORE;
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                end
                OP_BRZ: begin
                    ctrl     = CTRL_BRZ;
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
        reg_write = ctrl[6];
        is_branch = ctrl[4];
    end

    // Write-back target as a one-hot register mask (zero when no write-back)
    always_comb begin
        wb_onehot = '0;
        if (wb_we_i) begin
            wb_onehot = {{(NREG-1){1'b0}}, 1'b1} << wb_rd_i;
        end
    end

    // Pending view used for hazard detection
    always_comb begin
`ifdef WB_BYPASS_EN
        pending_eff = pending & ~wb_onehot;
`else
        pending_eff = pending;
`endif
    end

    // RAW on used sources, WAW on the destination of a register write
    always_comb begin
        hazard = (uses_rs1 && pending_eff[rs1]) ||
                 (uses_rs2 && pending_eff[rs2]) ||
                 (reg_write && pending_eff[rd]);
    end

    // Per-lane asynchronous operand read with optional write-back forwarding
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        for (int l = 0; l < LANES; l++) begin
            rs1_val[l*DW +: DW] = rf[l][rs1];
            rs2_val[l*DW +: DW] = rf[l][rs2];
`ifdef WB_BYPASS_EN
            if (wb_we_i && wb_lane_mask_i[l] && (wb_rd_i == rs1)) begin
                rs1_val[l*DW +: DW] = wb_data_i[l*DW +: DW];
            end
            if (wb_we_i && wb_lane_mask_i[l] && (wb_rd_i == rs2)) begin
                rs2_val[l*DW +: DW] = wb_data_i[l*DW +: DW];
            end
`endif
        end
    end

    // Replicated register files: per-lane masked synchronous write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < NREG; r++) begin
                    rf[l][r] <= '0;
                end
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (wb_we_i && wb_lane_mask_i[l]) begin
                    rf[l][wb_rd_i] <= wb_data_i[l*DW +: DW];
                end
            end
        end
    end

    // Branch FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Branch FSM next state, decode handshake and issue
    always_comb begin
        state_next  = state;
        dec_ready_o = 1'b0;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                dec_ready_o = !rst && !hazard && (ex_ready_i || !ex_valid_o);
                issue       = inst_valid_i && dec_ready_o;
                if (issue && is_branch) begin
                    state_next = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (br_resolved_i) begin
                    state_next = zero_flag_i ? BR_REDIRECT : IDLE;
                end
            end
            BR_REDIRECT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Redirect outputs are flops aligned with the one-cycle BR_REDIRECT state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_pc_o <= 1'b0;
            flush_o  <= 1'b0;
        end else begin
            sel_pc_o <= (state_next == BR_REDIRECT);
            flush_o  <= (state_next == BR_REDIRECT);
        end
    end

    // Branch target latched when the branch issues
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_pc_o <= '0;
        end else if (issue && is_branch) begin
            branch_pc_o <= inst_i[PCW-1:0];
        end
    end

    // Scoreboard update: write-back clears, issue of a register write sets (set wins)
    always_comb begin
        pending_next = pending & ~wb_onehot;
        if (issue && reg_write) begin
            pending_next[rd] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // ID/EX pipeline register: loads when empty or drained, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_o <= 1'b0;
            ex_rs1_o   <= '0;
            ex_rs2_o   <= '0;
            ex_rd_o    <= '0;
            ex_ctrl_o  <= '0;
        end else if (ex_ready_i || !ex_valid_o) begin
            ex_valid_o <= issue;
            if (issue) begin
                ex_rs1_o  <= rs1_val;
                ex_rs2_o  <= rs2_val;
                ex_rd_o   <= rd;
                ex_ctrl_o <= ctrl;
            end
        end
    end

endmodule

// File: tb/tb_vec_decode_stage.sv
// tb_vec_decode_stage: directed scenarios plus randomized traffic for
// vec_decode_stage, checked against a cycle-level behavioural model.
module tb_vec_decode_stage;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned PCW   = 8;
    localparam int unsigned VW    = LANES * DW;

    logic                clk = 1'b0;
    logic                rst;
    logic                inst_valid;
    logic [15:0]         inst;
    logic                dec_ready;
    logic                wb_we;
    logic [3:0]          wb_rd;
    logic [LANES-1:0]    wb_lane_mask;
    logic [VW-1:0]       wb_data;
    logic                zero_flag;
    logic                br_resolved;
    logic                ex_ready;
    logic                ex_valid;
    logic [VW-1:0]       ex_rs1;
    logic [VW-1:0]       ex_rs2;
    logic [3:0]          ex_rd;
    logic [6:0]          ex_ctrl;
    logic                sel_pc;
    logic [PCW-1:0]      branch_pc;
    logic                flush;

    vec_decode_stage #(.LANES(LANES), .DW(DW), .PCW(PCW)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid_i   (inst_valid),
        .inst_i         (inst),
        .dec_ready_o    (dec_ready),
        .wb_we_i        (wb_we),
        .wb_rd_i        (wb_rd),
        .wb_lane_mask_i (wb_lane_mask),
        .wb_data_i      (wb_data),
        .zero_flag_i    (zero_flag),
        .br_resolved_i  (br_resolved),
        .ex_ready_i     (ex_ready),
        .ex_valid_o     (ex_valid),
        .ex_rs1_o       (ex_rs1),
        .ex_rs2_o       (ex_rs2),
        .ex_rd_o        (ex_rd),
        .ex_ctrl_o      (ex_ctrl),
        .sel_pc_o       (sel_pc),
        .branch_pc_o    (branch_pc),
        .flush_o        (flush)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0]  m_rf [LANES][16];
    logic [15:0]    m_pend;
    bit             m_wait;
    bit             m_redir;
    logic [PCW-1:0] m_bpc;
    bit             m_exv;
    logic [VW-1:0]  m_rs1, m_rs2;
    logic [3:0]     m_rd;
    logic [6:0]     m_ctrl;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_of(input logic [3:0] op);
        logic [6:0] c;
        c = 7'd0;
        if (op < 4'd8)       c = 7'd64 + 7'(op);   // regWrite + aluCtrl
        else if (op == 4'h8) c = 7'd64 + 7'd8;     // regWrite + resultSrc
        else if (op == 4'h9) c = 7'd32;            // memWrite
        else if (op == 4'hA) c = 7'd16;            // branch
        return c;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LANES; l++)
            for (int r = 0; r < 16; r++) m_rf[l][r] = '0;
        m_pend = '0; m_wait = 0; m_redir = 0; m_bpc = '0;
        m_exv = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
    endtask

    task automatic drive_idle();
        inst_valid = 0; inst = '0; wb_we = 0; wb_rd = '0; wb_lane_mask = '0;
        wb_data = '0; zero_flag = 0; br_resolved = 0; ex_ready = 1;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check handshake, advance model
    task automatic cycle(input bit iv, input logic [15:0] ins, input bit we, input logic [3:0] wrd,
                         input logic [LANES-1:0] msk, input logic [VW-1:0] wd,
                         input bit zf, input bit brr, input bit exr);
        logic [3:0]    op, rd, a, b;
        logic [15:0]   pe;
        logic [VW-1:0] o1, o2;
        bit            rw, u1, u2, haz, rdy, iss;
        @(negedge clk);
        check("ex_valid", ex_valid, m_exv);
        check("ex_rs1", ex_rs1, m_rs1);
        check("ex_rs2", ex_rs2, m_rs2);
        check("ex_rd", ex_rd, m_rd);
        check("ex_ctrl", ex_ctrl, m_ctrl);
        check("sel_pc", sel_pc, m_redir);
        check("flush", flush, m_redir);
        check("branch_pc", branch_pc, m_bpc);
        inst_valid = iv; inst = ins; wb_we = we; wb_rd = wrd; wb_lane_mask = msk;
        wb_data = wd; zero_flag = zf; br_resolved = brr; ex_ready = exr;
        #1;
        op = ins[15:12]; rd = ins[11:8]; a = ins[7:4]; b = ins[3:0];
        rw = (op <= 4'h8);
        u1 = (op <= 4'hA);
        u2 = (op <= 4'h7) || (op == 4'h9) || (op == 4'hA);
        pe = m_pend;
`ifdef WB_BYPASS_EN
        if (we) pe[wrd] = 1'b0;
`endif
        haz = (u1 && pe[a]) || (u2 && pe[b]) || (rw && pe[rd]);
        rdy = !m_wait && !m_redir && !haz && (exr || !m_exv);
        iss = iv && rdy;
        check("dec_ready", dec_ready, rdy);
        for (int l = 0; l < LANES; l++) begin
            o1[l*DW +: DW] = m_rf[l][a];
            o2[l*DW +: DW] = m_rf[l][b];
`ifdef WB_BYPASS_EN
            if (we && msk[l] && wrd == a) o1[l*DW +: DW] = wd[l*DW +: DW];
            if (we && msk[l] && wrd == b) o2[l*DW +: DW] = wd[l*DW +: DW];
`endif
        end
        if (exr || !m_exv) begin
            m_exv = iss;
            if (iss) begin
                m_rs1 = o1; m_rs2 = o2; m_rd = rd; m_ctrl = ctrl_of(op);
            end
        end
        if (we) m_pend[wrd] = 1'b0;
        if (iss && rw) m_pend[rd] = 1'b1;
        for (int l = 0; l < LANES; l++)
            if (we && msk[l]) m_rf[l][wrd] = wd[l*DW +: DW];
        if (m_redir) m_redir = 0;
        else if (m_wait) begin
            if (brr) begin
                m_wait = 0;
                m_redir = zf;
            end
        end else if (iss && op == 4'hA) begin
            m_wait = 1;
            m_bpc = ins[PCW-1:0];
        end
        @(posedge clk);
    endtask

    // Asynchronous reset between clock edges, outputs must clear immediately
    task automatic do_reset();
        @(negedge clk);
        #2;
        drive_idle();
        rst = 1;
        #1;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_rs1", ex_rs1, 0);
        check("rst_ex_rs2", ex_rs2, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_ex_ctrl", ex_ctrl, 0);
        check("rst_sel_pc", sel_pc, 0);
        check("rst_flush", flush, 0);
        check("rst_branch_pc", branch_pc, 0);
        check("rst_dec_ready", dec_ready, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    logic [VW-1:0] all1234;
    logic [VW-1:0] masked_exp;
    logic [3:0]    pick;

    initial begin
        drive_idle();
        model_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // T2: write-back r3 then ALU op reading it
        all1234 = {LANES{16'h1234}};
        cycle(0, 16'h0, 1, 4'd3, 4'hF, all1234, 0, 0, 1);
        cycle(1, 16'h2530, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        #1;
        check("t2_valid", ex_valid, 1);
        check("t2_rs1", ex_rs1, all1234);
        check("t2_rd", ex_rd, 4'd5);
        check("t2_alu", ex_ctrl, 7'b100_0010);

        // T3: RAW stall on r4 until its write-back
        cycle(1, 16'h1400, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        repeat (3) cycle(1, 16'h2640, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        cycle(1, 16'h2640, 1, 4'd4, 4'hF, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0, 0, 1);
        cycle(1, 16'h2640, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        cycle(0, 16'h0, 0, 4'd0, 4'h0, '0, 0, 0, 1);

        // T4: backpressure holds ID/EX for 5 cycles, then the next instruction loads
        cycle(1, 16'h9120, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        repeat (5) cycle(1, 16'h9230, 0, 4'd0, 4'h0, '0, 0, 0, 0);
        cycle(1, 16'h9230, 0, 4'd0, 4'h0, '0, 0, 0, 1);

        // T5: branch taken after clearing r5/r6
        cycle(0, 16'h0, 1, 4'd5, 4'hF, {LANES{16'h0055}}, 0, 0, 1);
        cycle(0, 16'h0, 1, 4'd6, 4'hF, {LANES{16'h0066}}, 0, 0, 1);
        cycle(1, 16'hA05A, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        repeat (2) cycle(1, 16'h9000, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        cycle(1, 16'h9000, 0, 4'd0, 4'h0, '0, 1, 1, 1);
        #1;
        check("t5_sel_pc", sel_pc, 1);
        check("t5_flush", flush, 1);
        check("t5_branch_pc", branch_pc, 8'h5A);
        cycle(0, 16'h0, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        #1;
        check("t5_sel_pc_drop", sel_pc, 0);

        // T6: branch not taken, then partial-lane write-back of r7
        cycle(1, 16'hA010, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        cycle(0, 16'h0, 0, 4'd0, 4'h0, '0, 0, 1, 1);
        #1;
        check("t6_no_sel_pc", sel_pc, 0);
        cycle(0, 16'h0, 1, 4'd7, 4'b0101, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 0, 0, 1);
        cycle(1, 16'h9077, 0, 4'd0, 4'h0, '0, 0, 0, 1);
        #1;
        masked_exp = {16'h0000, 16'hCCCC, 16'h0000, 16'hAAAA};
        check("t6_masked_rs1", ex_rs1, masked_exp);

        // T1: mid-run reset, then every register reads back zero
        do_reset();
        for (int r = 0; r < 16; r++)
            cycle(1, {4'h9, 4'h0, 4'(r), 4'(r)}, 0, 4'd0, 4'h0, '0, 0, 0, 1);

        // Randomized traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            pick = 4'($urandom_range(0, 15));
            if (m_pend != 16'd0 && $urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 16; k++) begin
                    if (m_pend[4'(int'(pick) + k)]) begin
                        pick = 4'(int'(pick) + k);
                        break;
                    end
                end
            end
            cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1, pick,
                  4'($urandom), {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7);
        end
        cycle(0, 16'h0, 0, 4'd0, 4'h0, '0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
